// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface instr_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Prefetch FIFO holding {instruction, pc}; flush has priority over push/pop.
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  fetch_entry_t                   wdata,
    output fetch_entry_t                   rdata,
    output logic [$clog2(DEPTH + 1)-1:0]   count,
    output logic                           empty,
    output logic                           full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset: nothing is read while count is zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues imem fetches, buffers words, handles redirects.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky fetch_fault on misaligned redirects.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instr_fetch_unit_if.master        imem,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [31:0]               instruction,
    output logic [31:0]               instr_pc
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic                      fetch_fault
`endif
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    fetch_state_t   state;
    logic [31:0]    fetch_pc;
    logic [31:0]    rsp_pc;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  outstanding_nxt;
    logic [CW-1:0]  discard;
    logic [CW-1:0]  discard_nxt;
    logic [CW-1:0]  fifo_count;
    logic           fifo_empty;
    logic           fifo_full;
    logic           fault;
    logic           issue;
    logic           drop;
    logic           push;
    logic           pop;
    logic [31:0]    target_pc;
    logic           target_bad;
    fetch_entry_t   push_data;
    fetch_entry_t   head;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target_pc   = redirect_pc;
    assign target_bad  = (redirect_pc[1:0] != 2'b00);
    assign fetch_fault = fault;
`else
    assign target_pc   = redirect_pc & ~32'h3;
    assign target_bad  = 1'b0;
`endif

    // Issue/response decode; a redirect suppresses the request and drops any rvalid word.
    always_comb begin
        imem.imem_req   = (state != BOOT) && !redirect_valid && !fault &&
                          ((SW'(fifo_count) + SW'(outstanding)) < SW'(FIFO_DEPTH));
        issue           = imem.imem_req && imem.imem_gnt;
        drop            = imem.imem_rvalid && (redirect_valid || (discard != '0));
        push            = imem.imem_rvalid && !drop && !fifo_full;
        pop             = instr_valid && instr_ready && !redirect_valid;
        outstanding_nxt = outstanding + CW'(issue) - CW'(imem.imem_rvalid);
        discard_nxt     = discard;
        if (redirect_valid) begin
            discard_nxt = outstanding_nxt;
        end else if (drop) begin
            discard_nxt = discard - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            fault       <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;
            state       <= (discard_nxt != '0) ? DRAIN : RUN;
            if (redirect_valid) begin
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                fault    <= target_bad;
            end else begin
                if (issue) fetch_pc <= fetch_pc + PC_STEP;
                if (push)  rsp_pc   <= rsp_pc + PC_STEP;
            end
        end
    end

    // Responses arrive in order, so the next kept word belongs to rsp_pc.
    assign push_data      = '{instr: imem.imem_rdata, pc: rsp_pc};
    assign imem.imem_addr = fetch_pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (push_data),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign instr_valid = !fifo_empty && !fault;
    assign instruction = instr_valid ? head.instr : INSTR_NOP;
    assign instr_pc    = instr_valid ? head.pc : 32'h0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized run
// checked against an in-order instruction-stream model and an imem responder model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    instr_fetch_unit_if imem_bus ();

    instr_fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem_bus.master),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_fault    (fetch_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] got_pc[$];
    logic [31:0] gnt_addr[$];
    int          cyc, last_due, lat_min, lat_max, gnt_pct;
    int          first_gnt_cyc, first_valid_cyc;
    int          n_checks, n_err;
    logic [31:0] exp_pc;
    bit          exp_fault, prev_stall, prev_redirect;
    logic [31:0] prev_addr;

    // Memory image: a bijective function of the address, so stale words are detectable.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hBAD0_BAD0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory response, check outputs, update models.
    task automatic cycle();
        bit rv, iss;
        int due;
        rv = (pend.size() > 0) && (pend[0].due <= cyc);
        imem_bus.imem_rvalid = rv;
        imem_bus.imem_rdata  = rv ? word_at(pend[0].addr) : 32'hDEAD_BEEF;
        imem_bus.imem_gnt    = ($urandom_range(99) < gnt_pct);
        #1;
        iss = 1'b0;
        if (rst_n) begin
            if (prev_stall && !redirect_valid) begin
                check("req_hold", 32'(imem_bus.imem_req), 32'd1);
                check("addr_hold", imem_bus.imem_addr, prev_addr);
            end
            if (redirect_valid) check("req_on_redirect", 32'(imem_bus.imem_req), 32'd0);
            if (prev_redirect)  check("valid_after_redirect", 32'(instr_valid), 32'd0);
            if (exp_fault)      check("valid_in_fault", 32'(instr_valid), 32'd0);
            if (!instr_valid) begin
                check("nop_when_idle", instruction, NOP);
                check("pc_when_idle", instr_pc, 32'h0);
            end else if (first_valid_cyc < 0) begin
                first_valid_cyc = cyc;
            end
            if (imem_bus.imem_req) check("addr_aligned", 32'(imem_bus.imem_addr[1:0]), 32'd0);
            if (instr_valid && instr_ready && !redirect_valid) begin
                check("stream_pc", instr_pc, exp_pc);
                check("stream_word", instruction, word_at(exp_pc));
                got_pc.push_back(instr_pc);
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
                exp_pc    = redirect_pc;
                exp_fault = (redirect_pc[1:0] != 2'b00);
`else
                exp_pc    = redirect_pc & ~32'h3;
`endif
            end
            iss = imem_bus.imem_req && imem_bus.imem_gnt;
            if (iss) begin
                gnt_addr.push_back(imem_bus.imem_addr);
                if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
            end
            prev_stall    = imem_bus.imem_req && !imem_bus.imem_gnt;
            prev_addr     = imem_bus.imem_addr;
            prev_redirect = redirect_valid;
        end
        @(posedge clk);
        if (rst_n) begin
            if (iss) begin
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{addr: prev_addr, due: due});
            end
            if (rv) void'(pend.pop_front());
            check("outstanding_bound", 32'(pend.size() <= DEPTH), 32'd1);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        cycle();
        redirect_valid = 1'b0;
    endtask

    // Asserts reset (memory is reset with it), checks reset outputs, then releases.
    task automatic apply_reset(input string tag);
        rst_n                = 1'b0;
        imem_bus.imem_gnt    = 1'b0;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata  = 32'h0;
        redirect_valid       = 1'b0;
        pend.delete();
        got_pc.delete();
        gnt_addr.delete();
        last_due = 0; exp_pc = RST_PC; exp_fault = 1'b0;
        prev_stall = 1'b0; prev_redirect = 1'b0;
        first_gnt_cyc = -1; first_valid_cyc = -1;
        #1;
        check({tag, "_req"}, 32'(imem_bus.imem_req), 32'd0);
        check({tag, "_addr"}, imem_bus.imem_addr, RST_PC);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instr"}, instruction, NOP);
        check({tag, "_pc"}, instr_pc, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        check({tag, "_fault"}, 32'(fetch_fault), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit found;
        n_checks = 0; n_err = 0; cyc = 0;
        redirect_pc = 32'h0; instr_ready = 1'b1;
        gnt_pct = 100; lat_min = 1; lat_max = 1;

        // Reset, boot cycle, first fetches and grant->valid latency
        apply_reset("reset");
        #1;
        check("boot_no_req", 32'(imem_bus.imem_req), 32'd0);
        run(14);
        check("t1_gnt0", q_at(gnt_addr, 0), 32'h0);
        check("t1_gnt1", q_at(gnt_addr, 1), 32'h4);
        check("t1_gnt2", q_at(gnt_addr, 2), 32'h8);
        check("t1_pc0", q_at(got_pc, 0), 32'h0);
        check("t1_pc1", q_at(got_pc, 1), 32'h4);
        check("t1_pc2", q_at(got_pc, 2), 32'h8);
        check("t1_latency", 32'(first_valid_cyc - first_gnt_cyc), 32'd2);

        // Back-pressure: exactly DEPTH grants, then one pop frees one request slot
        instr_ready = 1'b0;
        redirect(32'h40);
        gnt_addr.delete();
        run(10);
        check("t2_grants", 32'(gnt_addr.size()), 32'(DEPTH));
        #1;
        check("t2_req_off", 32'(imem_bus.imem_req), 32'd0);
        check("t2_head_pc", instr_pc, 32'h40);
        got_pc.delete(); gnt_addr.delete();
        instr_ready = 1'b1;
        cycle();
        instr_ready = 1'b0;
        run(6);
        check("t2_one_pop", 32'(got_pc.size()), 32'd1);
        check("t2_pop_pc", q_at(got_pc, 0), 32'h40);
        check("t2_one_req", 32'(gnt_addr.size()), 32'd1);

        // Grant stall at 0x8: address and request hold, no pc skip
        instr_ready = 1'b1;
        run(6);
        gnt_pct = 0;
        run(4);
        redirect(32'h8);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_req", 32'(imem_bus.imem_req), 32'd1);
            check("t3_addr", imem_bus.imem_addr, 32'h8);
            cycle();
        end
        gnt_pct = 100;
        got_pc.delete();
        run(8);
        check("t3_pc0", q_at(got_pc, 0), 32'h8);
        check("t3_pc1", q_at(got_pc, 1), 32'hC);

        // Redirect with two fetches in flight
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20; i++) begin
            if (pend.size() == DEPTH) break;
            cycle();
        end
        check("t4_two_outst", 32'(pend.size()), 32'(DEPTH));
        got_pc.delete();
        redirect(32'h100);
        run(14);
        check("t4_pc0", q_at(got_pc, 0), 32'h100);
        check("t4_pc1", q_at(got_pc, 1), 32'h104);

        // Redirect coinciding with a pop and an rvalid
        lat_min = 1; lat_max = 1;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (instr_valid && pend.size() > 0 && pend[0].due <= cyc) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        check("t5_found", 32'(found), 32'd1);
        got_pc.delete();
        redirect(32'h300);
        run(8);
        check("t5_pc0", q_at(got_pc, 0), 32'h300);
        check("t5_pc1", q_at(got_pc, 1), 32'h304);

        // Fetch address wrap
        got_pc.delete();
        redirect(32'hFFFF_FFF8);
        run(10);
        check("wrap_pc0", q_at(got_pc, 0), 32'hFFFF_FFF8);
        check("wrap_pc1", q_at(got_pc, 1), 32'hFFFF_FFFC);
        check("wrap_pc2", q_at(got_pc, 2), 32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned redirect faults; an aligned one clears it
        redirect(32'h102);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t6_fault", 32'(fetch_fault), 32'd1);
            check("t6_no_req", 32'(imem_bus.imem_req), 32'd0);
            cycle();
        end
        got_pc.delete();
        redirect(32'h200);
        #1;
        check("t6_fault_clr", 32'(fetch_fault), 32'd0);
        run(8);
        check("t6_pc0", q_at(got_pc, 0), 32'h200);
`else
        // Low redirect bits are ignored
        got_pc.delete();
        redirect(32'h503);
        run(8);
        check("align_pc0", q_at(got_pc, 0), 32'h500);
        check("align_pc1", q_at(got_pc, 1), 32'h504);
`endif

        // Randomized traffic against the stream model
        gnt_pct = 60; lat_min = 1; lat_max = 3;
        got_pc.delete();
        for (int i = 0; i < 600; i++) begin
            instr_ready = ($urandom_range(99) < 70);
            if ($urandom_range(99) < 4) begin
`ifdef FETCH_ALIGN_CHECK_EN
                redirect({20'h0, 10'($urandom_range(1023)), 2'b00});
`else
                redirect({20'h0, 12'($urandom_range(4095))});
`endif
            end else begin
                cycle();
            end
        end
        check("rand_progress", 32'(got_pc.size() >= 50), 32'd1);

        // Reset in the middle of traffic
        apply_reset("midreset");
        gnt_pct = 100; lat_min = 1; lat_max = 1; instr_ready = 1'b1;
        run(10);
        check("midreset_pc0", q_at(got_pc, 0), RST_PC);
        check("midreset_pc1", q_at(got_pc, 1), RST_PC + 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
